// File: rtl/acc_store_ctl.sv
// Store-path bus sequencer: latches accumulator/address on st_req and runs setup/write/hold/done.
// Optional read-back check compiled in with `define STORE_VERIFY_EN.
module acc_store_ctl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 13,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_req,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] accum,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    output logic          mem_oe,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_din,
    output logic          verify_err
);

    localparam int unsigned CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] data_r, data_nxt;
    logic [AW-1:0] addr_r, addr_nxt;
    logic          err_nxt;
    logic          busy_nxt, done_nxt, oe_nxt, wr_nxt, rd_nxt;
    logic [DW-1:0] dout_nxt;

`ifndef STORE_VERIFY_EN
    logic unused_din;
    assign unused_din = ^mem_din;
`endif

    // Next state plus output values decoded from the next state, so every output is a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_r;
        addr_nxt  = addr_r;
        err_nxt   = verify_err;

        case (state)
            S_IDLE: begin
                if (st_req) begin
                    data_nxt  = accum;
                    addr_nxt  = st_addr;
                    err_nxt   = 1'b0;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_nxt   = CW'(WR_CYCLES - 1);
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_HOLD: begin
`ifdef STORE_VERIFY_EN
                state_nxt = S_VERIFY;
`else
                state_nxt = S_DONE;
`endif
            end
            S_VERIFY: begin
`ifdef STORE_VERIFY_EN
                err_nxt = (mem_din != data_r);
`endif
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

`ifndef STORE_VERIFY_EN
        err_nxt = 1'b0;
`endif

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        oe_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_WRITE) || (state_nxt == S_HOLD);
        wr_nxt   = (state_nxt == S_WRITE);
`ifdef STORE_VERIFY_EN
        rd_nxt   = (state_nxt == S_VERIFY);
`else
        rd_nxt   = 1'b0;
`endif
        dout_nxt = oe_nxt ? data_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            data_r     <= '0;
            addr_r     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_oe     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            verify_err <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_r     <= data_nxt;
            addr_r     <= addr_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            mem_oe     <= oe_nxt;
            mem_wr     <= wr_nxt;
            mem_rd     <= rd_nxt;
            verify_err <= err_nxt;
            mem_addr   <= addr_nxt;
            mem_dout   <= dout_nxt;
        end
    end

endmodule

// File: doc/acc_store_ctl.md
Name: acc_store_ctl

Overview:
Store-side counterpart of the accumulator: on a store request (STO instruction), captures the accumulator value and target address, then drives them onto the memory data/address bus with a write strobe in a fixed setup/write/hold sequence.
- Sits between the accumulator/controller and data RAM.
- Owns bus-drive enable for the store path.
- Signals busy/done back to the CPU controller.

Parameters:
DW, 8, data/accumulator width
AW, 13, memory address width
WR_CYCLES, 2, number of cycles mem_wr is held high (legal range >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
st_req  in  1  store request from controller, sampled only in IDLE
st_addr  in  AW  store address, sampled with st_req
accum  in  DW  accumulator value, sampled with st_req
busy  out  1  high from cycle after acceptance through DONE
done  out  1  one-cycle pulse at end of store
mem_addr  out  AW  memory address
mem_dout  out  DW  write data to bus
mem_oe  out  1  bus drive enable (external tri-state control)
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe (verify feature only)
mem_din  in  DW  memory read data (verify feature only)
verify_err  out  1  read-back mismatch flag (verify feature only)

Behaviour:
- Reset: state=IDLE; busy, done, mem_oe, mem_wr, mem_rd, verify_err = 0; mem_addr = 0; mem_dout = 0; internal data/addr latches = 0.
- Reset mid-operation: next edge returns to IDLE with all outputs 0; no done pulse; store is abandoned.
- All outputs are registered or decoded purely from registered state/latches; no combinational path from inputs to outputs.
- IDLE: if st_req=1 at edge, latch accum->data_r, st_addr->addr_r, go SETUP.
- SETUP (1 cycle): busy=1, mem_oe=1, mem_addr=addr_r, mem_dout=data_r, mem_wr=0.
- WRITE (WR_CYCLES cycles, down-counter): mem_wr=1, mem_oe=1; address and data held stable.
- HOLD (1 cycle): mem_wr=0, mem_oe=1, data and address held.
- DONE (1 cycle): done=1, busy=1, mem_oe=0, mem_wr=0; then IDLE.
- mem_dout = data_r while mem_oe=1, else 0.
- mem_addr holds the last addr_r in all states.
- Latency: st_req accepted at edge 0 -> SETUP cycle 1 -> WRITE cycles 2..WR_CYCLES+1 -> HOLD -> done at cycle WR_CYCLES+3 (cycle 5 with default).
- Inputs captured once: changes to accum/st_addr after acceptance have no effect on the in-flight store.
- st_req while busy (including the DONE cycle) is ignored, not queued. The next request is accepted in the first IDLE cycle.
- The counter width covers WR_CYCLES. WR_CYCLES=1 gives exactly one mem_wr cycle.

Optional Feature:
STORE_VERIFY_EN
- Defined: after HOLD, a VERIFY state (1 cycle) is inserted with mem_oe=0, mem_wr=0, mem_rd=1. mem_din is sampled at the end of VERIFY and compared to data_r.
- verify_err is set on mismatch, coincident with done. It is held until the next accepted st_req (cleared at acceptance) or rst.
- Latency becomes WR_CYCLES+4.
- Undefined: no VERIFY state; mem_rd and verify_err tied 0; mem_din ignored.

Test Plan:
- Basic store: rst released, accum=8'hA5, st_addr=13'h0123, st_req pulse -> mem_oe high cycles 1-4, mem_wr high cycles 2-3, mem_dout=A5, mem_addr=0123, done pulse at cycle 5, busy high cycles 1-5.
- Capture isolation: accum changes to 8'h3C one cycle after request -> mem_dout stays A5 throughout.
- Busy rejection: st_req held high continuously with accum=8'h11 then 8'h22 -> second store starts in the IDLE cycle after done; no overlap; exactly one mem_wr burst per accepted request.
- Reset mid-write: rst asserted during the first WRITE cycle -> next edge all outputs 0, no done, and a fresh request afterwards completes normally.
- WR_CYCLES=1 build: single request -> mem_wr exactly one cycle, done at cycle 4.
- STORE_VERIFY_EN: store 8'h5A, memory model returns 8'h5B -> mem_rd one cycle after HOLD, done and verify_err=1 at cycle 6. Next request clears verify_err; a matching read-back leaves it 0.
